bus_sequencer: RTL and testbench
================================

// Module: bus_sequencer
// PURPOSE
//  Bus master for the shared CPLD peripheral bus (8-bit addr/data, active-low ce_n/read_n/write_n).
//  Arbitrates two requesters (0 = host/SPI side, 1 = local refresh engine) round-robin.
//  Runs each granted access as SETUP/STROBE/HOLD phases with programmable lengths.
//  Returns read data and a one-cycle done pulse to the owning requester.
//  Sits between the requester logic and the bussed peripherals (switch, LED, RAM controllers).
// PARAMETERS
//  SETUP_CYC   1  cycles ce_n/addr valid before strobe (min 1)
//  STROBE_CYC  2  cycles read_n/write_n held low (min 1)
//  HOLD_CYC    1  cycles ce_n/addr/wdata held after strobe release (min 1)
// PORTS
//  clk       in     1  system clock, all state on rising edge
//  reset_n   in     1  asynchronous, active-low reset
//  req0      in     1  requester 0 access request, held high until done0
//  we0       in     1  requester 0: 1 = write, 0 = read
//  addr0     in     8  requester 0 address
//  wdata0    in     8  requester 0 write data
//  req1/we1/addr1/wdata1  in  1/1/8/8  same for requester 1
//  done0     out    1  one-cycle pulse: requester 0 access complete
//  done1     out    1  one-cycle pulse: requester 1 access complete
//  rdata     out    8  read data of last completed read, valid from done pulse until next read
//  busy      out    1  high in any state other than IDLE
//  bus_addr  out    8  peripheral address
//  bus_data  inout  8  peripheral data, driven only during write accesses
//  ce_n      out    1  bus chip enable, active low
//  read_n    out    1  read strobe, active low
//  write_n   out    1  write strobe, active low
// BEHAVIOUR
//  Reset (async, reset_n low): state IDLE; ce_n=read_n=write_n=1; bus_addr=0; bus_data=Z;
//    rdata=0; done0=done1=0; busy=0; round-robin pointer favours requester 0.
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE. Phase counter reloads on each phase entry.
//  IDLE: if exactly one reqN high, grant it. If both high, grant the one not granted last.
//    On grant: latch we/addr/wdata of winner, record owner, go SETUP next cycle.
//  SETUP (SETUP_CYC cycles): ce_n=0, strobes high, bus_addr=latched addr, bus_data=wdata if write else Z.
//  STROBE (STROBE_CYC cycles): ce_n=0; read_n=0 on read, write_n=0 on write (never both).
//    Read: rdata captured from bus_data on the clock edge ending the last STROBE cycle.
//  HOLD (HOLD_CYC cycles): strobes high, ce_n=0, addr and write data still driven.
//  DONE (1 cycle): ce_n=1, bus_data=Z, doneN=1 for owner only; pointer updated to owner. Then IDLE.
//  Latency: req sampled high in IDLE at edge k -> ce_n low from k+1; done at k+1+SETUP+STROBE+HOLD.
//  Back-to-back: min one IDLE cycle between transactions; a req still high in IDLE is re-arbitrated.
//  reqN dropping mid-transaction: ignored; access completes and done still pulses.
//  Input changes after grant: ignored (latched values used).
//  All bus outputs registered (glitch-free strobes). bus_data never driven while read_n=0.
//  Reset mid-transaction: immediate return to reset values; no done pulse.
// TESTING
//  1 Read, req1 only, addr1=8'h02, model drives 8'hA5 while ce_n&read_n low, defaults ->
//    ce_n low 4 cycles, read_n low 2, done1 once, rdata=8'hA5, done0 never.
//  2 Write, req0, addr0=8'h01, wdata0=8'h3C -> bus_data=8'h3C from ce_n fall to ce_n rise;
//    write_n low exactly STROBE_CYC cycles, read_n stays 1.
//  3 req0 and req1 both held high for 4 accesses -> grant order 0,1,0,1; done pulses alternate.
//  4 SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2 -> req at edge k gives done at k+8;
//    strobe edges land on the matching cycles.
//  5 reset_n low during STROBE of a write -> same cycle ce_n=write_n=1, bus_data=Z, no done;
//    after release, pending req0 served normally.
//  6 req0 dropped in SETUP, addr0 changed in STROBE -> access completes with original addr, done0 pulses.

Source files
------------

// File: rtl/bus_sequencer_if.sv
// Requester handshake and peripheral bus control signals of bus_sequencer.
// bus_data is tri-state and is carried as a separate port on the sequencer.
interface bus_sequencer_if;
    logic       req0;
    logic       we0;
    logic [7:0] addr0;
    logic [7:0] wdata0;
    logic       req1;
    logic       we1;
    logic [7:0] addr1;
    logic [7:0] wdata1;
    logic       done0;
    logic       done1;
    logic [7:0] rdata;
    logic       busy;
    logic [7:0] bus_addr;
    logic       ce_n;
    logic       read_n;
    logic       write_n;

    modport master (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        output done0, done1, rdata, busy, bus_addr, ce_n, read_n, write_n
    );

    modport slave (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        input  done0, done1, rdata, busy, bus_addr, ce_n, read_n, write_n
    );
endinterface

// File: rtl/bus_sequencer.sv
// Round-robin bus master for the shared CPLD peripheral bus: two requesters,
// each access run as SETUP/STROBE/HOLD phases followed by a one-cycle done.
module bus_sequencer #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    bus_sequencer_if.master bus,
    inout  wire  [7:0]      bus_data
);
    localparam int unsigned MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MAX_CYC = (STROBE_CYC > MAX_SH) ? STROBE_CYC : MAX_SH;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          ce_n_q, ce_n_d;
    logic          read_n_q, read_n_d;
    logic          write_n_q, write_n_d;
    logic          drive_q, drive_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          busy_q, busy_d;
    logic          grant1;
    logic          active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ce_n_q    <= 1'b1;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
            drive_q   <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ce_n_q    <= ce_n_d;
            read_n_q  <= read_n_d;
            write_n_q <= write_n_d;
            drive_q   <= drive_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        grant1  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // last_q names the previous winner; on contention the other side wins.
                    grant1  = bus.req1 && (!bus.req0 || !last_q);
                    owner_d = grant1;
                    we_d    = grant1 ? bus.we1    : bus.we0;
                    addr_d  = grant1 ? bus.addr1  : bus.addr0;
                    wdata_d = grant1 ? bus.wdata1 : bus.wdata0;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                    if (!we_q) begin
                        rdata_d = bus_data;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                last_d  = owner_q;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are decoded from the next state and registered, so they
        // switch on the same edge as the phase and never glitch.
        active    = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        ce_n_d    = !active;
        read_n_d  = !((state_d == S_STROBE) && !we_d);
        write_n_d = !((state_d == S_STROBE) && we_d);
        drive_d   = active && we_d;
        done0_d   = (state_d == S_DONE) && !owner_d;
        done1_d   = (state_d == S_DONE) && owner_d;
        busy_d    = (state_d != S_IDLE);
    end

    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.bus_addr = addr_q;
    assign bus.ce_n     = ce_n_q;
    assign bus.read_n   = read_n_q;
    assign bus.write_n  = write_n_q;
    assign bus_data     = drive_q ? wdata_q : 'z;
endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: instance A with default phase lengths, instance B
// with stretched phases; peripherals answer reads with addr ^ 8'hA7.
module tb_bus_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bus_sequencer_if ifa ();
    bus_sequencer_if ifb ();
    wire [7:0] bdata_a;
    wire [7:0] bdata_b;

    bus_sequencer dut_a (
        .clk      (clk),
        .reset_n  (rst_n),
        .bus      (ifa),
        .bus_data (bdata_a)
    );

    bus_sequencer #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_b (
        .clk      (clk),
        .reset_n  (rst_n),
        .bus      (ifb),
        .bus_data (bdata_b)
    );

    assign bdata_a = (!ifa.ce_n && !ifa.read_n) ? (ifa.bus_addr ^ 8'hA7) : 8'hzz;
    assign bdata_b = (!ifb.ce_n && !ifb.read_n) ? (ifb.bus_addr ^ 8'hA7) : 8'hzz;

    typedef struct packed {
        logic       owner;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } txn_t;

    txn_t        sb [$];
    txn_t        vecs [8];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ce_cnt = 0, rd_cnt = 0, wr_cnt = 0, addr_bad = 0, data_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic owner, input logic we, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic [7:0] rdata);
        mk = txn_t'{owner: owner, we: we, addr: addr, wdata: wdata, rdata: rdata};
    endfunction

    // Requester A transaction monitor; the front of sb is the access in flight.
    initial begin : mon
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ce_cnt = 0; rd_cnt = 0; wr_cnt = 0; addr_bad = 0; data_bad = 0;
            end else begin
                if (!ifa.ce_n) begin
                    ce_cnt++;
                    if (sb.size() > 0) begin
                        if (ifa.bus_addr !== sb[0].addr) addr_bad++;
                        if (sb[0].we && (bdata_a !== sb[0].wdata)) data_bad++;
                    end
                end
                if (!ifa.read_n) rd_cnt++;
                if (!ifa.write_n) wr_cnt++;
                if (ifa.done0 || ifa.done1) begin
                    if (sb.size() == 0) begin
                        check("done_unexpected", {ifa.done1, ifa.done0}, 2'b00);
                    end else begin
                        t = sb.pop_front();
                        check("done_owner", {ifa.done1, ifa.done0}, t.owner ? 2'b10 : 2'b01);
                        check("ce_low_cycles", ce_cnt, 4);
                        check("read_low_cycles", rd_cnt, t.we ? 0 : 2);
                        check("write_low_cycles", wr_cnt, t.we ? 2 : 0);
                        check("addr_stable", addr_bad, 0);
                        if (t.we) check("wdata_on_bus", data_bad, 0);
                        else      check("rdata", ifa.rdata, t.rdata);
                        check("busy_at_done", ifa.busy, 1'b1);
                        check("ce_n_at_done", ifa.ce_n, 1'b1);
                    end
                    ce_cnt = 0; rd_cnt = 0; wr_cnt = 0; addr_bad = 0; data_bad = 0;
                end
            end
        end
    end

    task automatic drive_req(input txn_t t);
        if (t.owner) begin
            ifa.req1 = 1'b1; ifa.we1 = t.we;  ifa.addr1 = t.addr;  ifa.wdata1 = t.wdata;
            ifa.req0 = 1'b0; ifa.we0 = ~t.we; ifa.addr0 = ~t.addr; ifa.wdata0 = ~t.wdata;
        end else begin
            ifa.req0 = 1'b1; ifa.we0 = t.we;  ifa.addr0 = t.addr;  ifa.wdata0 = t.wdata;
            ifa.req1 = 1'b0; ifa.we1 = ~t.we; ifa.addr1 = ~t.addr; ifa.wdata1 = ~t.wdata;
        end
        sb.push_back(t);
    endtask

    task automatic wait_done_a(input int unsigned budget, output int unsigned lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < budget) begin
            @(negedge clk);
            lat++;
            seen = ifa.done0 || ifa.done1;
        end
        check("done_seen", seen, 1'b1);
    endtask

    task automatic wait_low_a(input int unsigned sel, input string name);
        int unsigned n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       seen = !ifa.ce_n;
                1:       seen = !ifa.read_n;
                default: seen = !ifa.write_n;
            endcase
        end
        check(name, seen, 1'b1);
    endtask

    task automatic run_b(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rdata);
        int unsigned first_ce, last_ce, first_st, last_st, done_at, wrong, bad;
        first_ce = 0; last_ce = 0; first_st = 0; last_st = 0; done_at = 0; wrong = 0; bad = 0;
        ifb.req1 = 1'b1; ifb.we1 = we; ifb.addr1 = addr; ifb.wdata1 = wdata;
        for (int c = 1; c <= 20 && done_at == 0; c++) begin
            @(negedge clk);
            if (!ifb.ce_n) begin
                if (first_ce == 0) first_ce = c;
                last_ce = c;
                if (we && (bdata_b !== wdata)) bad++;
            end
            if (!(we ? ifb.write_n : ifb.read_n)) begin
                if (first_st == 0) first_st = c;
                last_st = c;
            end
            if (!(we ? ifb.read_n : ifb.write_n)) wrong++;
            if (ifb.done1) done_at = c;
        end
        ifb.req1 = 1'b0;
        check("b_first_ce", first_ce, 1);
        check("b_last_ce", last_ce, 7);
        check("b_first_strobe", first_st, 3);
        check("b_last_strobe", last_st, 5);
        check("b_done_cycle", done_at, 8);
        check("b_wrong_strobe", wrong, 0);
        if (we) check("b_wdata_on_bus", bad, 0);
        else    check("b_rdata", ifb.rdata, exp_rdata);
        @(negedge clk);
        check("b_busy_idle", ifb.busy, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned lat;
        vecs[0] = mk(1'b1, 1'b0, 8'h02, 8'h00, 8'hA5);
        vecs[1] = mk(1'b0, 1'b1, 8'h01, 8'h3C, 8'h00);
        vecs[2] = mk(1'b0, 1'b0, 8'h01, 8'h00, 8'hA6);
        vecs[3] = mk(1'b1, 1'b1, 8'h80, 8'h5A, 8'h00);
        vecs[4] = mk(1'b1, 1'b0, 8'h80, 8'h00, 8'h27);
        vecs[5] = mk(1'b0, 1'b0, 8'hFF, 8'h00, 8'h58);
        vecs[6] = mk(1'b0, 1'b1, 8'h00, 8'hC3, 8'h00);
        vecs[7] = mk(1'b1, 1'b0, 8'h10, 8'h00, 8'hB7);

        ifa.req0 = 1'b0; ifa.we0 = 1'b0; ifa.addr0 = '0; ifa.wdata0 = '0;
        ifa.req1 = 1'b0; ifa.we1 = 1'b0; ifa.addr1 = '0; ifa.wdata1 = '0;
        ifb.req0 = 1'b0; ifb.we0 = 1'b0; ifb.addr0 = '0; ifb.wdata0 = '0;
        ifb.req1 = 1'b0; ifb.we1 = 1'b0; ifb.addr1 = '0; ifb.wdata1 = '0;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ce_n", ifa.ce_n, 1'b1);
        check("rst_read_n", ifa.read_n, 1'b1);
        check("rst_write_n", ifa.write_n, 1'b1);
        check("rst_bus_addr", ifa.bus_addr, 8'h00);
        check("rst_rdata", ifa.rdata, 8'h00);
        check("rst_done", {ifa.done1, ifa.done0}, 2'b00);
        check("rst_busy", ifa.busy, 1'b0);
        check("rst_b_ce_n", ifb.ce_n, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            drive_req(vecs[i]);
            wait_done_a(20, lat);
            check("latency", lat, 5);
            ifa.req0 = 1'b0;
            ifa.req1 = 1'b0;
            @(negedge clk);
            check("busy_idle", ifa.busy, 1'b0);
        end

        // Both requesters held: previous winner was 1, so order is 0,1,0,1.
        ifa.req0 = 1'b1; ifa.we0 = 1'b0; ifa.addr0 = 8'h02; ifa.wdata0 = 8'h00;
        ifa.req1 = 1'b1; ifa.we1 = 1'b1; ifa.addr1 = 8'h33; ifa.wdata1 = 8'hE1;
        for (int n = 0; n < 2; n++) begin
            sb.push_back(mk(1'b0, 1'b0, 8'h02, 8'h00, 8'hA5));
            sb.push_back(mk(1'b1, 1'b1, 8'h33, 8'hE1, 8'h00));
        end
        for (int n = 0; n < 4; n++) begin
            wait_done_a(20, lat);
            check("rr_latency", lat, (n == 0) ? 5 : 6);
        end
        ifa.req0 = 1'b0;
        ifa.req1 = 1'b0;
        @(negedge clk);
        check("rr_busy_idle", ifa.busy, 1'b0);

        // req0 dropped in SETUP, inputs changed in STROBE: latched access completes.
        drive_req(mk(1'b0, 1'b0, 8'h40, 8'h00, 8'hE7));
        wait_low_a(0, "t6_ce_low");
        ifa.req0 = 1'b0;
        wait_low_a(1, "t6_read_low");
        ifa.addr0 = 8'h41; ifa.we0 = 1'b1; ifa.wdata0 = 8'hFF;
        wait_done_a(20, lat);
        repeat (3) @(negedge clk);
        check("t6_no_regrant", ifa.ce_n, 1'b1);

        // Reset during the strobe of a write; the held req0 is served afterwards.
        drive_req(mk(1'b0, 1'b1, 8'h20, 8'h77, 8'h00));
        wait_low_a(2, "t5_write_low");
        rst_n = 1'b0;
        #1;
        check("t5_ce_n", ifa.ce_n, 1'b1);
        check("t5_write_n", ifa.write_n, 1'b1);
        check("t5_busy", ifa.busy, 1'b0);
        repeat (2) @(negedge clk);
        check("t5_no_done", {ifa.done1, ifa.done0}, 2'b00);
        rst_n = 1'b1;
        wait_done_a(20, lat);
        check("t5_latency", lat, 5);
        ifa.req0 = 1'b0;
        @(negedge clk);
        check("t5_busy_idle", ifa.busy, 1'b0);

        run_b(1'b1, 8'h06, 8'h99, 8'h00);
        run_b(1'b0, 8'h05, 8'h00, 8'hA2);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
